// File: rtl/nn_pkg.sv
// Shared neural-network constants and types: Q8.24 fixed-point values,
// the default datapath width and the arbiter response record.
package nn_pkg;

  localparam int ACT_WIDTH  = 32;
  localparam int ACT_ID_MAX = 4;

  localparam logic signed [ACT_WIDTH-1:0] Q_ONE  = 32'sh0100_0000;
  localparam logic signed [ACT_WIDTH-1:0] Q_ZERO = 32'sh0000_0000;

  typedef struct packed {
    logic [ACT_ID_MAX-1:0] id;
    logic [ACT_WIDTH-1:0]  data;
  } act_rsp_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/act_clamp.sv
// Purely combinational signed saturation of a fixed-point value to
// [CLAMP_LO, CLAMP_HI]; both bounds pass through unchanged.
module act_clamp
  import nn_pkg::*;
#(
  parameter int                      WIDTH    = ACT_WIDTH,
  parameter logic signed [WIDTH-1:0] CLAMP_LO = Q_ZERO,
  parameter logic signed [WIDTH-1:0] CLAMP_HI = Q_ONE
) (
  input  logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] y
);

  always_comb begin
    if (x < CLAMP_LO)      y = CLAMP_LO;
    else if (x > CLAMP_HI) y = CLAMP_HI;
    else                   y = x;
  end

endmodule

// File: rtl/activation_arbiter.sv
// Round-robin arbiter sharing one registered activation clamp among NUM_REQ
// neuron accumulators. Optional saturation counters: ACT_SAT_STATS_EN.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Requesters hold data until accepted; the result slot holds
// rsp_id/rsp_data stable while rsp_valid && !rsp_ready.
module activation_arbiter
  import nn_pkg::*;
#(
  parameter int                      NUM_REQ  = 4,
  parameter int                      WIDTH    = ACT_WIDTH,
  parameter logic signed [WIDTH-1:0] CLAMP_LO = Q_ZERO,
  parameter logic signed [WIDTH-1:0] CLAMP_HI = Q_ONE,
  localparam int                     IDW      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_data
`ifdef ACT_SAT_STATS_EN
  ,
  input  logic                     stat_clear,
  output logic [15:0]              sat_hi_cnt,
  output logic [15:0]              sat_lo_cnt
`endif
);

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [IDW-1:0]     ptr);
    logic [IDW-1:0] pick;
    int             idx;
    pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (v[idx]) pick = IDW'(idx);
    end
    return pick;
  endfunction

  slot_state_t              state;
  logic [IDW-1:0]           rr_ptr;
  logic [IDW-1:0]           win;
  logic [IDW-1:0]           ptr_nxt;
  logic                     slot_avail;
  logic                     accept;
  logic signed [WIDTH-1:0]  win_data;
  logic signed [WIDTH-1:0]  clamped;

  assign win        = rr_pick(req_valid, rr_ptr);
  assign ptr_nxt    = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  assign slot_avail = (state == SLOT_EMPTY) || rsp_ready;
  assign win_data   = req_data[win*WIDTH +: WIDTH];
  assign accept     = |(req_valid & req_ready);
  assign rsp_valid  = (state == SLOT_FULL);

  // Gated by reset_n so no grant is ever offered while reset is held.
  always_comb begin
    req_ready = '0;
    if (reset_n && slot_avail && (|req_valid)) req_ready[win] = 1'b1;
  end

  act_clamp #(
    .WIDTH    (WIDTH),
    .CLAMP_LO (CLAMP_LO),
    .CLAMP_HI (CLAMP_HI)
  ) u_clamp (
    .x (win_data),
    .y (clamped)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SLOT_EMPTY;
      rr_ptr   <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: if (accept) state <= SLOT_FULL;
        SLOT_FULL:  if (rsp_ready && !accept) state <= SLOT_EMPTY;
        default:    state <= SLOT_EMPTY;
      endcase
      if (accept) begin
        rsp_id   <= win;
        rsp_data <= clamped;
        rr_ptr   <= ptr_nxt;
      end
    end
  end

`ifdef ACT_SAT_STATS_EN
  logic sat_hi_evt;
  logic sat_lo_evt;

  assign sat_hi_evt = accept && (win_data > CLAMP_HI);
  assign sat_lo_evt = accept && (win_data < CLAMP_LO);

  // Clear has priority over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_hi_cnt <= '0;
      sat_lo_cnt <= '0;
    end else if (stat_clear) begin
      sat_hi_cnt <= '0;
      sat_lo_cnt <= '0;
    end else begin
      if (sat_hi_evt && (sat_hi_cnt != 16'hFFFF)) sat_hi_cnt <= sat_hi_cnt + 16'd1;
      if (sat_lo_evt && (sat_lo_cnt != 16'hFFFF)) sat_lo_cnt <= sat_lo_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_activation_arbiter.sv
// Self-checking bench for activation_arbiter: a queue-based reference model
// checked every negedge, plus directed scenarios with literal expectations.
module tb_activation_arbiter;
  import nn_pkg::*;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam logic signed [W-1:0] LO = 32'sh0000_0000;
  localparam logic signed [W-1:0] HI = 32'sh0100_0000;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_data;
`ifdef ACT_SAT_STATS_EN
  logic            stat_clear;
  logic [15:0]     sat_hi_cnt;
  logic [15:0]     sat_lo_cnt;
`endif

  int       n_checks = 0;
  int       n_fail   = 0;
  act_rsp_t exp_q[$];
  act_rsp_t out_log[$];
  int       m_ptr = 0;
  int       m_hi  = 0;
  int       m_lo  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  activation_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
`ifdef ACT_SAT_STATS_EN
    ,
    .stat_clear (stat_clear),
    .sat_hi_cnt (sat_hi_cnt),
    .sat_lo_cnt (sat_lo_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mclamp(input logic signed [W-1:0] x);
    if (x < LO) return LO;
    if (x > HI) return HI;
    return x;
  endfunction

  // ---------------- scoreboard / model ----------------
  always @(negedge clk) begin
    int            win;
    int            j;
    logic          avail;
    logic [NR-1:0] er;
    logic signed [W-1:0] x;
    act_rsp_t      r;
    if (!reset_n) begin
      exp_q.delete();
      m_ptr = 0;
      m_hi  = 0;
      m_lo  = 0;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_data", rsp_data, 0);
    end else begin
      avail = (exp_q.size() == 0) || rsp_ready;
      win = -1;
      for (int k = 0; k < NR; k++) begin
        j = (m_ptr + k) % NR;
        if (win < 0 && req_valid[j]) win = j;
      end
      er = '0;
      if (avail && win >= 0) er[win] = 1'b1;
      check("req_ready", req_ready, er);
      check("rsp_valid", rsp_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("rsp_id", rsp_id, exp_q[0].id);
        check("rsp_data", rsp_data, exp_q[0].data);
      end
`ifdef ACT_SAT_STATS_EN
      check("sat_hi_cnt", sat_hi_cnt, m_hi);
      check("sat_lo_cnt", sat_lo_cnt, m_lo);
`endif
      if (rsp_valid && rsp_ready) begin
        r.id   = 4'(rsp_id);
        r.data = rsp_data;
        out_log.push_back(r);
      end
      if (rsp_ready && exp_q.size() != 0) r = exp_q.pop_front();
      x = '0;
      if (er != '0) begin
        x      = req_data[win*W +: W];
        r.id   = 4'(win);
        r.data = mclamp(x);
        exp_q.push_back(r);
        m_ptr = (win + 1) % NR;
      end
`ifdef ACT_SAT_STATS_EN
      if (stat_clear) begin
        m_hi = 0;
        m_lo = 0;
      end else if (er != '0) begin
        if (x > HI && m_hi < 65535) m_hi++;
        if (x < LO && m_lo < 65535) m_lo++;
      end
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold every raised request until it is granted, then drop it.
  task automatic drain_drop(input int max_cycles);
    logic [NR-1:0] acc;
    for (int c = 0; c < max_cycles && req_valid != '0; c++) begin
      #1;
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
    end
    check("drain_timeout", req_valid, 0);
  endtask

  task automatic send_one(input int id, input logic [W-1:0] val);
    req_data[id*W +: W] = val;
    req_valid[id] = 1'b1;
    drain_drop(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [W-1:0] t2_exp [4];
    t2_exp[0] = 32'h0000_0000;
    t2_exp[1] = 32'h0100_0000;
    t2_exp[2] = 32'h0100_0000;
    t2_exp[3] = 32'h0000_0000;

    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
`ifdef ACT_SAT_STATS_EN
    stat_clear = 1'b0;
`endif
    repeat (3) tick();
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_data", rsp_data, 0);
    req_valid = '1;
    #1;
    check("reset_ready_gated", req_ready, 0);
    req_valid = '0;
    tick();
    reset_n = 1'b1;
    tick();

    // Single requester 2
    req_data[2*W +: W] = 32'h0080_0000;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    check("t1_ready", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    req_valid = '0;
    #1;
    check("t1_valid", rsp_valid, 1);
    check("t1_id", rsp_id, 2);
    check("t1_data", rsp_data, 32'h0080_0000);
    tick();

    // Reset pulse brings the pointer back to 0
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Clamp corners, served in order 0..3
    out_log.delete();
    req_data[0*W +: W] = 32'hFFFF_0000;
    req_data[1*W +: W] = 32'h0300_0000;
    req_data[2*W +: W] = 32'h0100_0000;
    req_data[3*W +: W] = 32'h0000_0000;
    req_valid = '1;
    drain_drop(10);
    tick();
    tick();
    check("t2_count", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) begin
      check("t2_id", out_log[i].id, i);
      check("t2_data", out_log[i].data, t2_exp[i]);
    end

    // All four held for 8 cycles: back-to-back round robin
    out_log.delete();
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = 32'h0010_0000 * (i + 1);
    req_valid = '1;
    repeat (8) tick();
    req_valid = '0;
    tick();
    tick();
    check("t3_count", out_log.size(), 8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) begin
      check("t3_id", out_log[i].id, i % 4);
      check("t3_data", out_log[i].data, 32'h0010_0000 * ((i % 4) + 1));
    end

    // Backpressure: slot held, req 1 waits
    rsp_ready = 1'b0;
    send_one(3, 32'h0040_0000);
    req_data[1*W +: W] = 32'h0200_0000;
    req_valid = 4'b0010;
    repeat (5) begin
      #1;
      check("t4_ready_hold", req_ready, 0);
      check("t4_data_hold", rsp_data, 32'h0040_0000);
      check("t4_id_hold", rsp_id, 3);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("t4_ready_release", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    req_valid = '0;
    #1;
    check("t4_valid", rsp_valid, 1);
    check("t4_id", rsp_id, 1);
    check("t4_data", rsp_data, 32'h0100_0000);
    tick();

    // Reset while FULL
    rsp_ready = 1'b0;
    send_one(0, 32'h0001_0000);
    #1;
    check("t5_full", rsp_valid, 1);
    reset_n = 1'b0;
    #1;
    check("t5_reset_drop", rsp_valid, 0);
    tick();
    tick();
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    #1;
    check("t5_first_grant", req_ready, 4'b0001);
    drain_drop(10);
    tick();
    tick();

`ifdef ACT_SAT_STATS_EN
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    send_one(0, 32'h0200_0000);
    send_one(1, 32'hFFFF_FFFF);
    send_one(2, 32'h7FFF_FFFF);
    send_one(3, 32'h0100_0000);
    send_one(0, 32'h8000_0000);
    send_one(1, 32'h0000_0000);
    send_one(2, 32'h0100_0001);
    #1;
    check("stat_hi", sat_hi_cnt, 3);
    check("stat_lo", sat_lo_cnt, 2);
    stat_clear = 1'b1;
    send_one(3, 32'h0500_0000);
    stat_clear = 1'b0;
    #1;
    check("stat_hi_clear", sat_hi_cnt, 0);
    check("stat_lo_clear", sat_lo_cnt, 0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/activation_arbiter.md
# activation_arbiter

Round-robin scheduler that shares one registered activation clamp stage among `NUM_REQ` neuron accumulators. Each neuron presents a signed fixed-point sum; the arbiter grants one request per cycle, clamps the sum to `[CLAMP_LO, CLAMP_HI]` and returns the result tagged with the requester index over a valid/ready output. It sits between the neuron MAC array and the layer output buffer.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `WIDTH`, 32: data width, signed Q8.24.
- `CLAMP_LO`, 32'sh0000_0000: lower saturation bound, signed, 0.0.
- `CLAMP_HI`, 32'sh0100_0000: upper saturation bound, signed, 1.0. `CLAMP_LO <= CLAMP_HI` is required.
- `IDW`, derived as `$clog2(NUM_REQ)`: requester index width.

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester valid.
- `req_data`  in  NUM_REQ*WIDTH  packed sums. Requester i uses bits `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  NUM_REQ  one-hot accept, combinational.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  downstream accept.
- `rsp_id`  out  IDW  index of the requester that produced the result.
- `rsp_data`  out  WIDTH  clamped result.

## Operation
- Output slot FSM has two states:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on `rsp_ready` with no new accept.
  - FULL stays FULL on `rsp_ready` with a simultaneous accept; the slot is refilled the same cycle.
  - FULL stays FULL on `!rsp_ready`, holding data.
- Slot is available when `state==EMPTY || rsp_ready`.
- Arbitration:
  - Round-robin pointer `rr_ptr`. Priority order is `rr_ptr, rr_ptr+1, …` modulo `NUM_REQ`.
  - The winner is the first requester with `req_valid` set.
  - `req_ready[winner]=1` only while the slot is available. All other bits are 0.
- Accept means `req_valid[i] && req_ready[i]`. On accept, the slot loads `rsp_id=i` and `rsp_data=clamp(req_data[i])`, and `rr_ptr <= i+1` modulo `NUM_REQ`.
- `rr_ptr` does not change when nothing is accepted.
- Clamp uses a signed compare:
  - `x < CLAMP_LO` → `CLAMP_LO`.
  - otherwise `x > CLAMP_HI` → `CLAMP_HI`.
  - otherwise `x` unchanged.
  - Both bounds are inclusive pass-through. No rounding.
- Requesters must hold `req_valid` and `req_data` stable until accepted. Dropping `req_valid` before accept is legal; the request is simply lost.
- While FULL and `!rsp_ready`, `rsp_id` and `rsp_data` are held stable.

## Timing
- Reset values: `state=EMPTY`, `rr_ptr=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`. `req_ready` is 0 while in reset.
- Latency: accept in cycle N → `rsp_valid` in cycle N+1.
- Throughput: 1 result/cycle with `rsp_ready` held high.
- Fairness: a requester with valid held waits at most `NUM_REQ-1` accepts.
- Reset asserted mid-operation: any held result is discarded and the pointer returns to 0.
- `rsp_ready` with `rsp_valid=0` is ignored.

## Configuration
- `ACT_SAT_STATS_EN` defined adds:
  - Ports `stat_clear` (in, 1), `sat_hi_cnt` (out, 16) and `sat_lo_cnt` (out, 16).
  - Each counter increments on every accept whose input clamped to `CLAMP_HI` or `CLAMP_LO` respectively, strictly beyond the bound.
  - Counters saturate at 16'hFFFF and reset to 0.
  - `stat_clear` zeroes both counters. If it coincides with an increment event, the clear wins.
- `ACT_SAT_STATS_EN` undefined: these ports and counters do not exist. Datapath behaviour is identical.

## Structure
- Shared package `nn_pkg` holds:
  - Q8.24 constants `Q_ONE=32'sh0100_0000` and `Q_ZERO`.
  - The `WIDTH` default.
  - The `act_rsp_t` struct {id, data}.
- One sub-module, `act_clamp`: purely combinational signed clamp parameterised by `WIDTH`, `CLAMP_LO` and `CLAMP_HI`. It is instantiated once, after the request mux.
- Round-robin winner selection stays a function inside `activation_arbiter`.

## Test plan
- Reset, then requester 2 only valid with data 32'sh0080_0000 → `req_ready=4'b0100` same cycle; next cycle `rsp_valid=1`, `rsp_id=2`, `rsp_data=32'sh0080_0000`.
- Inputs 32'shFFFF_0000, 32'sh0300_0000, 32'sh0100_0000, 32'sh0000_0000 on req 0..3 → results 0, 32'sh0100_0000, 32'sh0100_0000, 0, in order id 0,1,2,3.
- All four valid and held for 8 cycles, `rsp_ready=1` → ids 0,1,2,3,0,1,2,3, one per cycle, no bubbles.
- Result held with `rsp_ready=0` for 5 cycles and req 1 valid → `req_ready=0` throughout, `rsp_data` stable. On `rsp_ready=1`, req 1 is accepted that cycle and appears next cycle.
- `reset_n` pulsed low while FULL → `rsp_valid` drops immediately. After release, all four valid → first grant is id 0.
- With `ACT_SAT_STATS_EN`: 3 over-range and 2 under-range inputs → `sat_hi_cnt=3`, `sat_lo_cnt=2`. `stat_clear` → both 0 next cycle.
